// File: rtl/output_mem_pkg.sv
// ---------------------------------------------------------------------------
// output_mem_pkg
// Shared definitions for the output-memory scan controller:
//   - scan_mode encodings driven onto the memory macro
//   - host command opcodes
//   - controller FSM states
//   - default memory depth and the command range check
// ---------------------------------------------------------------------------
package output_mem_pkg;

    localparam int MEM_DEPTH = 128;

    // 11 is both scan-out and the safe idle mode: the memory is never written in it.
    localparam logic [1:0] MODE_SCAN_IN  = 2'b00;
    localparam logic [1:0] MODE_RUN      = 2'b01;
    localparam logic [1:0] MODE_SCAN_OUT = 2'b11;

    typedef enum logic [1:0] {
        OP_SCAN_IN  = 2'd0,
        OP_RUN      = 2'd1,
        OP_SCAN_OUT = 2'd2,
        OP_RSVD     = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_IN,
        ST_RUN,
        ST_SCAN_OUT,
        ST_DRAIN
    } state_t;

    // A command touching addresses base .. base+len-1 must stay below depth.
    function automatic logic cmd_overruns(input int base, input int len, input int depth);
        return (base + len) > depth;
    endfunction

endpackage

// File: rtl/output_mem_rd_fifo.sv
// ---------------------------------------------------------------------------
// output_mem_rd_fifo
// Two-entry FIFO holding words read back from the memory scan port.
// The writer (scan controller) only pushes when it has reserved a slot, so
// there is no input-side ready.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid, in_data     push one word
//   out_valid, out_ready  standard valid/ready pop side
//   out_data              head word, stable while out_valid && !out_ready
//   count                 number of stored words (0..2)
// ---------------------------------------------------------------------------
module output_mem_rd_fifo #(
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] entry_reg [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;
    logic              push;
    logic              pop;

    assign push      = in_valid && (count_reg != 2'd2);
    assign pop       = out_valid && out_ready;
    assign out_valid = (count_reg != 2'd0);
    assign out_data  = entry_reg[rd_ptr_reg];
    assign count     = count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            entry_reg[0] <= '0;
            entry_reg[1] <= '0;
        end else begin
            if (push) begin
                entry_reg[wr_ptr_reg] <= in_data;
                wr_ptr_reg            <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/output_mem_scan_ctrl.sv
// ---------------------------------------------------------------------------
// output_mem_scan_ctrl
// Sequencer for the output memory's scan port. Accepts host commands
// (scan-in block, run window, scan-out block), drives scan_mode/addr/in,
// and streams read words back through a 2-entry backpressured FIFO.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   cmd_valid/ready, op, base, len   host command channel
//   wr_valid/ready, wr_data          host write words for SCAN_IN
//   rd_valid/ready, rd_data          read words from SCAN_OUT
//   mem_scan_mode/addr/in            registered drive to the memory
//   mem_scan_out                     memory read data, 1 clk after address
//   busy                             command in progress
//   err                              sticky illegal-op / overrun flag
// ---------------------------------------------------------------------------
module output_mem_scan_ctrl
    import output_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 512,
    parameter int DEPTH  = MEM_DEPTH,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        mem_scan_mode,
    output logic [ADDR_W-1:0] mem_scan_addr,
    output logic [DATA_W-1:0] mem_scan_in,
    input  logic [DATA_W-1:0] mem_scan_out,
    output logic              busy,
    output logic              err
);

    state_t            state_reg;
    logic [LEN_W-1:0]  rem_reg;     // words / cycles still to do
    logic [ADDR_W-1:0] addr_reg;    // next scan-in address
    logic              cap_reg;     // mem_scan_out carries an issued read this cycle
    logic [1:0]        fifo_count;
    logic [2:0]        fifo_claim;
    cmd_op_t           op;
    logic              cmd_fire;
    logic              wr_fire;
    logic              rd_fire;
    logic              issue;

    assign op       = cmd_op_t'(cmd_op);
    assign cmd_fire = cmd_valid && cmd_ready;
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;

    // The address register is already on the bus in SCAN_OUT, so a read is
    // "issued" in the cycle it is qualified here. Slots claimed at the next
    // edge = stored words + the word on mem_scan_out - the word leaving now.
    // Counting the pop keeps 1 word/cycle with only one read in flight.
    assign fifo_claim = 3'(fifo_count) + 3'(cap_reg) - 3'(rd_fire);
    assign issue      = (state_reg == ST_SCAN_OUT) && (rem_reg != '0) && (fifo_claim < 3'd2);

    output_mem_rd_fifo #(
        .DATA_W (DATA_W)
    ) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (cap_reg),
        .in_data   (mem_scan_out),
        .out_valid (rd_valid),
        .out_ready (rd_ready),
        .out_data  (rd_data),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            rem_reg       <= '0;
            addr_reg      <= '0;
            cap_reg       <= 1'b0;
            cmd_ready     <= 1'b1;
            wr_ready      <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
            mem_scan_mode <= MODE_SCAN_OUT;
            mem_scan_addr <= '0;
            mem_scan_in   <= '0;
        end else begin
            cap_reg <= issue;
            case (state_reg)
                ST_IDLE: begin
                    mem_scan_mode <= MODE_SCAN_OUT;
                    if (cmd_fire) begin
                        if (op == OP_RSVD) begin
                            err <= 1'b1;
                        end else if (cmd_len == '0) begin
                            // zero-length command: nothing to do
                        end else if (cmd_overruns(int'(cmd_base), int'(cmd_len), DEPTH)) begin
                            err <= 1'b1;
                        end else begin
                            rem_reg   <= cmd_len;
                            addr_reg  <= cmd_base;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                            case (op)
                                OP_SCAN_IN: begin
                                    state_reg <= ST_SCAN_IN;
                                    wr_ready  <= 1'b1;
                                end
                                OP_RUN: begin
                                    state_reg     <= ST_RUN;
                                    mem_scan_mode <= MODE_RUN;
                                end
                                default: begin
                                    state_reg     <= ST_SCAN_OUT;
                                    mem_scan_addr <= cmd_base;
                                end
                            endcase
                        end
                    end
                end

                ST_SCAN_IN: begin
                    if (rem_reg == '0) begin
                        // the last word was presented last cycle and is now captured
                        mem_scan_mode <= MODE_SCAN_OUT;
                        state_reg     <= ST_IDLE;
                        busy          <= 1'b0;
                        cmd_ready     <= 1'b1;
                    end else if (wr_fire) begin
                        mem_scan_mode <= MODE_SCAN_IN;
                        mem_scan_addr <= addr_reg;
                        mem_scan_in   <= wr_data;
                        addr_reg      <= addr_reg + 1'b1;
                        rem_reg       <= rem_reg - 1'b1;
                        if (rem_reg == LEN_W'(1)) begin
                            wr_ready <= 1'b0;
                        end
                    end else begin
                        // host stall: leave write mode so no stale word is rewritten
                        mem_scan_mode <= MODE_SCAN_OUT;
                    end
                end

                ST_RUN: begin
                    rem_reg <= rem_reg - 1'b1;
                    if (rem_reg == LEN_W'(1)) begin
                        mem_scan_mode <= MODE_SCAN_OUT;
                        state_reg     <= ST_IDLE;
                        busy          <= 1'b0;
                        cmd_ready     <= 1'b1;
                    end
                end

                ST_SCAN_OUT: begin
                    if (issue) begin
                        rem_reg <= rem_reg - 1'b1;
                        if (rem_reg == LEN_W'(1)) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            mem_scan_addr <= mem_scan_addr + 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    if ((fifo_count == 2'd0) && !cap_reg) begin
                        state_reg <= ST_IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_mem_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_output_mem_scan_ctrl
// Directed bench for output_mem_scan_ctrl. A behavioural memory answers the
// scan port; a reference image of intended memory contents and queues of
// expected writes / read words are checked every cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_output_mem_scan_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 512;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = 128;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        mem_scan_mode;
    logic [ADDR_W-1:0] mem_scan_addr;
    logic [DATA_W-1:0] mem_scan_in;
    logic [DATA_W-1:0] mem_scan_out;
    logic              busy;
    logic              err;

    output_mem_scan_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_base      (cmd_base),
        .cmd_len       (cmd_len),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .mem_scan_mode (mem_scan_mode),
        .mem_scan_addr (mem_scan_addr),
        .mem_scan_in   (mem_scan_in),
        .mem_scan_out  (mem_scan_out),
        .busy          (busy),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATA_W-1:0] mk_word(input int k);
        logic [DATA_W-1:0] w;
        for (int j = 0; j < DATA_W / 32; j++) begin
            w[j*32 +: 32] = 32'(k) * 32'h9E37_79B1 + 32'(j) * 32'h0101_0101;
        end
        return w;
    endfunction

    // Memory macro stand-in: writes in mode 00, registered read every cycle.
    logic [DATA_W-1:0] tb_mem [256];
    always @(posedge clk) begin
        if (mem_scan_mode == 2'b00) tb_mem[mem_scan_addr] <= mem_scan_in;
        mem_scan_out <= tb_mem[mem_scan_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model / scoreboard state ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic [DATA_W-1:0] ref_mem [256];
    wr_t               exp_wr [$];
    logic [DATA_W-1:0] exp_rd [$];
    int                wr_cyc [$];
    int                wr_addr [$];
    int                rd_cyc [$];
    int                run_cycles = 0;
    int                rd_hs = 0;
    int                acc_cyc = 0;
    int                idle_cyc = 0;
    int                n_cmp = 0;
    int                n_bad = 0;
    logic              rd_toggle = 1'b0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    initial begin
        logic              prev_stall;
        logic [DATA_W-1:0] prev_data;
        wr_t               e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (mem_scan_mode == 2'b00) begin
                    if (exp_wr.size() == 0) begin
                        chki("unexpected_write", int'(mem_scan_addr), -1);
                    end else begin
                        e = exp_wr.pop_front();
                        chki("wr_addr", int'(mem_scan_addr), int'(e.addr));
                        chk("wr_data", mem_scan_in, e.data);
                        wr_cyc.push_back(cyc);
                        wr_addr.push_back(int'(mem_scan_addr));
                    end
                end
                if (mem_scan_mode == 2'b01) begin
                    run_cycles++;
                    chki("cmd_ready_in_run", int'(cmd_ready), 0);
                end
                if (mem_scan_mode == 2'b10) chki("illegal_mode", int'(mem_scan_mode), 3);
                if (prev_stall) begin
                    chki("stall_valid", int'(rd_valid), 1);
                    chk("stall_data", rd_data, prev_data);
                end
                if (rd_valid && rd_ready) begin
                    if (exp_rd.size() == 0) begin
                        chki("unexpected_rd", int'(rd_valid), 0);
                    end else begin
                        chk("rd_data", rd_data, exp_rd.pop_front());
                    end
                    rd_cyc.push_back(cyc);
                    rd_hs++;
                end
                prev_stall = rd_valid && !rd_ready;
                prev_data  = rd_data;
            end
        end
    end

    // rd_ready driver: steady 1, or toggling each cycle
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rd_ready = rd_toggle ? ~rd_ready : 1'b1;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic check_reset_values(input string tag);
        chki({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        chki({tag, "_wr_ready"}, int'(wr_ready), 0);
        chki({tag, "_rd_valid"}, int'(rd_valid), 0);
        chki({tag, "_busy"}, int'(busy), 0);
        chki({tag, "_err"}, int'(err), 0);
        chki({tag, "_mode"}, int'(mem_scan_mode), 3);
        chki({tag, "_addr"}, int'(mem_scan_addr), 0);
        chk({tag, "_scan_in"}, mem_scan_in, '0);
    endtask

    task automatic send_cmd(input int op, input int base, input int len);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_base  = ADDR_W'(base);
        cmd_len   = LEN_W'(len);
        while (!cmd_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chki("cmd_ready_wait", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        $display("cmd op=%0d base=%0d len=%0d accepted at cycle %0d", op, base, len, acc_cyc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle_cyc = cyc;
        chki("idle_reached", int'(busy), 0);
    endtask

    task automatic do_scan_in(input int base, input int len, input int stall_every, input int dbase);
        wr_t  e;
        int   k;
        int   t;
        logic hs;
        for (int i = 0; i < len; i++) begin
            e.addr = ADDR_W'(base + i);
            e.data = mk_word(dbase + i);
            exp_wr.push_back(e);
            ref_mem[base + i] = e.data;
        end
        wr_cyc.delete();
        wr_addr.delete();
        send_cmd(0, base, len);
        k = 0;
        t = 0;
        while (k < len && t < 500) begin
            wr_valid = !(stall_every != 0 && (t % stall_every) == stall_every - 1);
            wr_data  = mk_word(dbase + k);
            @(negedge clk);
            hs = wr_valid && wr_ready;
            @(posedge clk);
            #1;
            if (hs) k++;
            t++;
        end
        wr_valid = 1'b0;
        chki("wr_words_taken", k, len);
        wait_idle();
    endtask

    task automatic do_scan_out(input int base, input int len);
        for (int i = 0; i < len; i++) exp_rd.push_back(ref_mem[base + i]);
        rd_cyc.delete();
        send_cmd(2, base, len);
    endtask

    task automatic check_three_reads(input string tag);
        chki({tag, "_count"}, rd_cyc.size(), 3);
        if (rd_cyc.size() >= 3) begin
            chki({tag, "_lat0"}, rd_cyc[0] - acc_cyc, 2);
            chki({tag, "_lat1"}, rd_cyc[1] - acc_cyc, 3);
            chki({tag, "_lat2"}, rd_cyc[2] - acc_cyc, 4);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int hs0;
        int runs0;
        int n;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_base  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  <= mk_word(1000 + i);
            ref_mem[i]  = mk_word(1000 + i);
        end
        repeat (3) @(posedge clk);
        #2;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // scan-in 3 words at 4, host always ready
        do_scan_in(4, 3, 0, 0);
        chki("wr_n", wr_addr.size(), 3);
        if (wr_addr.size() >= 3) begin
            chki("wr_addr0", wr_addr[0], 4);
            chki("wr_addr1", wr_addr[1], 5);
            chki("wr_addr2", wr_addr[2], 6);
            chki("wr_consecutive", wr_cyc[2] - wr_cyc[0], 2);
            chki("idle_after_write", idle_cyc - wr_cyc[2], 1);
        end
        chki("post_wr_mode", int'(mem_scan_mode), 3);
        chki("post_wr_wr_ready", int'(wr_ready), 0);

        // scan-out the same block at full throughput
        do_scan_out(4, 3);
        chki("first_issue_addr", int'(mem_scan_addr), 4);
        wait_idle();
        check_three_reads("so1");

        // scan-in 8 words with host stalls, scan-out with rd_ready toggling
        do_scan_in(20, 8, 3, 100);
        chki("wr8_n", wr_addr.size(), 8);
        rd_toggle = 1'b1;
        do_scan_out(20, 8);
        wait_idle();
        rd_toggle = 1'b0;
        chki("so8_count", rd_cyc.size(), 8);

        // run window
        run_cycles = 0;
        send_cmd(1, 0, 5);
        wait_idle();
        chki("run_cycles", run_cycles, 5);
        chki("post_run_mode", int'(mem_scan_mode), 3);

        // overrun: 126 + 4 > 128
        hs0   = rd_hs;
        runs0 = run_cycles;
        send_cmd(2, 126, 4);
        chki("ovr_err", int'(err), 1);
        chki("ovr_cmd_ready", int'(cmd_ready), 1);
        chki("ovr_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chki("ovr_mode", int'(mem_scan_mode), 3);
        chki("ovr_no_run", run_cycles, runs0);
        chki("ovr_no_rd", rd_hs, hs0);

        // reset in the middle of a 6-word scan-out
        hs0 = rd_hs;
        do_scan_out(0, 6);
        n = 0;
        while (rd_hs < hs0 + 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chki("mid_reads", rd_hs - hs0, 2);
        reset = 1'b1;
        exp_rd.delete();
        #1;
        check_reset_values("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // normal command after reset
        do_scan_out(4, 3);
        wait_idle();
        check_three_reads("so2");

        // reserved opcode
        send_cmd(3, 0, 1);
        chki("rsvd_err", int'(err), 1);
        chki("rsvd_cmd_ready", int'(cmd_ready), 1);
        chki("rsvd_busy", int'(busy), 0);

        repeat (3) @(posedge clk);
        #1;
        chki("exp_rd_left", exp_rd.size(), 0);
        chki("exp_wr_left", exp_wr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
